// File: rtl/ex_mem_buffer.sv
// Two-entry EX/MEM skid FIFO between the ALU stage and the memory stage.
// Optional CBZ resolution on the head entry is enabled by defining EXMEM_BRANCH_RESOLVE_EN.
module ex_mem_buffer #(
    parameter int n = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] in_result,
    input  logic         in_z,
    input  logic [4:0]   in_rd,
    input  logic [3:0]   in_ctrl,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] out_result,
    output logic         out_z,
    output logic [4:0]   out_rd,
    output logic [3:0]   out_ctrl,
    output logic         out_branch_taken,
    output logic [1:0]   out_count
);

    typedef struct packed {
        logic [n-1:0] result;
        logic         z;
        logic [4:0]   rd;
        logic [3:0]   ctrl;
    } entry_t;

    entry_t     mem_q [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       push, pop;
    entry_t     head;

    // in_ready depends only on count_q, so out_ready never reaches it combinationally.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_count = count_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: payload storage is deliberately not reset; occupancy alone decides whether it is visible.
    always_ff @(posedge clk) begin
        if (rst_n && push && !flush) begin
            mem_q[wr_ptr_q] <= '{result: in_result, z: in_z, rd: in_rd, ctrl: in_ctrl};
        end
    end

    // Head fields are masked to zero while empty so stale payload never leaks out.
    assign head       = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_result = head.result;
    assign out_z      = head.z;
    assign out_rd     = head.rd;
    assign out_ctrl   = head.ctrl;

`ifdef EXMEM_BRANCH_RESOLVE_EN
    assign out_branch_taken = out_valid && head.ctrl[0] && head.z;
`else
    assign out_branch_taken = 1'b0;
`endif

endmodule

// File: doc/ex_mem_buffer.md
EX_MEM_BUFFER -- requirements
Module: ex_mem_buffer

Interface
REQ-001 SHALL have parameter n, default 64: width of the ALU result datapath.
REQ-002 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port flush, input, 1: discard all buffered entries (branch mispredict/exception).
REQ-005 SHALL have port in_valid, input, 1: ALU stage presents a valid result.
REQ-006 SHALL have port in_ready, output, 1: buffer can accept an entry this cycle.
REQ-007 SHALL have port in_result, input, n: ALU output1.
REQ-008 SHALL have port in_z, input, 1: ALU zero flag.
REQ-009 SHALL have port in_rd, input, 5: destination register index.
REQ-010 SHALL have port in_ctrl, input, 4: {mem_read, mem_write, reg_write, branch_cbz}.
REQ-011 SHALL have port out_valid, output, 1: head entry valid for the memory stage.
REQ-012 SHALL have port out_ready, input, 1: memory stage accepts head entry.
REQ-013 SHALL have ports out_result (n), out_z (1), out_rd (5), out_ctrl (4), outputs: head entry fields.
REQ-014 SHALL have port out_branch_taken, output, 1: CBZ resolution for head entry.
REQ-015 SHALL have port out_count, output, 2: occupancy, 0..2.

Function
REQ-016 SHALL store up to 2 entries {result, z, rd, ctrl} in FIFO order.
REQ-017 SHALL push when in_valid && in_ready, pop when out_valid && out_ready.
REQ-018 SHALL drive in_ready = (count < 2) from registered state only; no combinational path from out_ready to in_ready.
REQ-019 SHALL drive out_valid = (count != 0); out_* = head entry.
REQ-020 SHALL give 1-cycle latency: entry pushed at edge k is visible on out_* after edge k; no same-cycle bypass when empty.
REQ-021 SHALL hold out_* stable while out_valid && !out_ready.
REQ-022 Count 1, simultaneous push and pop: count stays 1, new entry becomes head next cycle.
REQ-023 Count 2: in_ready low, push ignored; pop alone -> count 1, second entry becomes head.
REQ-024 Count 0, pop attempt: no effect (out_valid low).
REQ-025 Read/write pointers SHALL be 1-bit and wrap 1 -> 0.
REQ-026 flush high SHALL set count 0 and both pointers 0 next edge; same-cycle push and pop ignored.
REQ-027 Entry payload registers need no reset; only count/pointers are reset-sensitive.

Reset
REQ-028 rst_n low at a clock edge SHALL set count 0, pointers 0; out_valid 0, in_ready 1 after that edge.
REQ-029 Reset SHALL take priority over flush, push and pop, including mid-transfer.
REQ-030 While count 0, out_result/out_rd/out_ctrl/out_z SHALL be driven 0 (masked), out_branch_taken 0.

Configuration
REQ-031 Macro EXMEM_BRANCH_RESOLVE_EN defined: out_branch_taken = out_valid && out_ctrl[0] && out_z.
REQ-032 Macro EXMEM_BRANCH_RESOLVE_EN undefined: out_branch_taken tied 0; port retained.

Verification
REQ-033 Reset: rst_n=0 one edge with count 2 -> out_valid 0, in_ready 1, out_count 0.
REQ-034 Single pass: push result 64'h5, rd 3, out_ready 1 -> next cycle out_valid 1, out_result 5, out_rd 3; following cycle out_valid 0.
REQ-035 Backpressure: out_ready 0, push 0xA,0xB,0xC back-to-back -> 0xA,0xB stored, in_ready low on third, 0xC not accepted; release out_ready -> 0xA then 0xB, order preserved.
REQ-036 Simultaneous push/pop at count 1 with 0x11 at head, pushing 0x22 -> count stays 1, out_result 0x22 next cycle.
REQ-037 Flush at count 2 with in_valid high -> count 0 next cycle, pushed entry discarded.
REQ-038 CBZ: push result 0, z 1, ctrl 4'b0001 -> out_branch_taken 1 with macro defined, 0 without.
